axi_wr_slave_mem: RTL and testbench
===================================

# axi_wr_slave_mem

Parametrised AXI write-path slave with a built-in byte-addressable memory. It is the first synthesisable DUT-side consumer of the AXI write address, write data and write response channel signal set. It accepts one burst at a time (FIXED, INCR or WRAP), writes strobed bytes into an internal word array, and returns a checked write response. A side read port exposes the array to the bench scoreboard.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, data bus width in bits; legal values are 32, 64, 128.
- ID_WIDTH, 8, transaction ID width.
- STRB_WIDTH, DATA_WIDTH/8, derived; not overridden.
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two.

Ports:
- sig_clock  in  1  clock; all logic on its rising edge.
- sig_reset  in  1  asynchronous, active-low reset.
- awid  in  ID_WIDTH  write address ID.
- awaddr  in  ADDR_WIDTH  burst start byte address.
- awlen  in  8  beats minus one.
- awsize  in  3  bytes per beat = 2^awsize.
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- awvalid  in  1  address valid.
- awready  out  1  address accepted.
- wid  in  ID_WIDTH  write data ID.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte lane enables.
- wlast  in  1  last beat marker.
- wvalid  in  1  data valid.
- wready  out  1  data accepted.
- bid  out  ID_WIDTH  response ID, equal to the latched awid.
- bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- bvalid  out  1  response valid.
- bready  in  1  response accepted.
- mem_idx  in  log2(MEM_DEPTH)  side read word index.
- mem_rdata  out  DATA_WIDTH  side read data, registered.

## Operation
The block is a three-state FSM: IDLE, DATA, RESP. Only one burst is outstanding at a time.

- **IDLE:** awready=1, wready=0, bvalid=0.
  - On awvalid&&awready, latch id, addr, len, size and burst, clear the beat counter and the error flags, then go to DATA.
- **Illegal bursts, flagged at AW time:** each sets err_slv, and no memory writes occur for that burst (its data is still drained).
  - awburst=11.
  - awsize > log2(STRB_WIDTH).
  - WRAP with awlen not in {1,3,7,15}.
- **DATA:** wready=1. On each handshake (wvalid&&wready):
  - If wid != latched id, set err_slv and do not write the beat.
  - Word index = addr >> log2(STRB_WIDTH). If index >= MEM_DEPTH, set err_dec and do not write.
  - Otherwise write each byte lane i where wstrb[i]=1; lanes with wstrb[i]=0 are left unchanged.
  - Address update:
    - FIXED: unchanged.
    - INCR: aligned(addr)+2^size.
    - WRAP: increment, then wrap inside the window aligned to (len+1)*2^size.
  - The burst ends on a beat where count==len or wlast=1:
    - wlast=1 with count<len (early) sets err_slv.
    - count==len without wlast sets err_slv.
  - At burst end go to RESP.
- **RESP:** bvalid=1, bid=latched id, bresp = 11 if err_dec, else 10 if err_slv, else 00. On bready go to IDLE.
- **mem_rdata:** equals mem[mem_idx] one cycle after mem_idx is presented. A write and a read to the same index in the same cycle returns the old data.
- **Memory:** contents are not cleared by reset.

## Timing
- **Reset (sig_reset=0):** state=IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=00, mem_rdata=0. awready rises on the first clock edge after release.
- All handshake outputs are registered; nothing is combinationally dependent on valid inputs.
- **AW accepted at edge N:** wready=1 from N+1.
- **Last beat accepted at edge M:** wready=0 and bvalid=1 from M+1.
- **B accepted at edge K:** awready=1 from K+1.
- Minimum burst occupancy is len+3 cycles.
- bvalid, bid and bresp hold stable until bready.
- wvalid with no open burst (IDLE or RESP) is ignored: wready=0.
- **Reset mid-burst:** immediate return to IDLE; beats already written persist; no response is issued.

## Test plan
- **INCR single-outstanding write:** after reset, AW id=5, addr=0x10, len=3, size=3, INCR, 4 full-strobe beats -> words 2..5 written; bvalid one cycle after the last beat with bid=5, bresp=00.
- **Strobes and FIXED:** FIXED, addr=0x08, len=1, beat0 wstrb=0x0F data=A, beat1 wstrb=0xF0 data=B -> word1 = {B[63:32],A[31:0]}; bresp=00.
- **WRAP:** WRAP, len=3, size=3, addr=0x18 -> beats land on words 3,0,1,2; WRAP with len=2 -> bresp=10 and memory unchanged.
- **Protocol errors:**
  - wlast on beat 1 of a len=3 burst -> burst ends and bresp=10.
  - wid mismatch -> that beat is not written and bresp=10.
  - addr=MEM_DEPTH*8 -> bresp=11.
- **Backpressure and reset:**
  - Hold bready=0 for 5 cycles -> bvalid, bid and bresp stable, awready=0.
  - Assert sig_reset mid-burst -> all outputs return to reset values; prior beats remain readable via mem_idx/mem_rdata.

Source files
------------

// File: rtl/axi_wr_slave_mem.sv
// AXI write-path slave with an internal strobed word memory and a registered side read port.
// Accepts one burst at a time (FIXED/INCR/WRAP) and returns OKAY/SLVERR/DECERR.
module axi_wr_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                         sig_clock,
   input  logic                         sig_reset,
   input  logic [ID_WIDTH-1:0]          awid,
   input  logic [ADDR_WIDTH-1:0]        awaddr,
   input  logic [7:0]                   awlen,
   input  logic [2:0]                   awsize,
   input  logic [1:0]                   awburst,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [ID_WIDTH-1:0]          wid,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [STRB_WIDTH-1:0]        wstrb,
   input  logic                         wlast,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [ID_WIDTH-1:0]          bid,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_idx,
   output logic [DATA_WIDTH-1:0]        mem_rdata
);
   localparam int LANE_SH = $clog2(STRB_WIDTH);
   localparam int IDX_W   = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
   state_t state, state_nxt;

   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, bytes, aligned, inc, wmask;
   logic [7:0]            len_q, cnt_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic                  bad_q, err_slv_q, err_dec_q;
   logic                  awready_nxt, wready_nxt, bvalid_nxt;
   logic                  aw_hs, w_hs, beat_last, id_bad, oob, we, illegal;
   logic                  err_slv_nxt, err_dec_nxt;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   assign aw_hs     = awvalid && awready;
   assign w_hs      = wvalid && wready;
   assign beat_last = w_hs && (cnt_q == len_q || wlast);
   assign id_bad    = wid != id_q;
   assign oob       = (addr_q >> LANE_SH) >= ADDR_WIDTH'(MEM_DEPTH);
   // bad_q blocks writes for the whole of an illegal burst; its beats are still drained
   assign we        = w_hs && !bad_q && !id_bad && !oob;
   assign illegal   = (awburst == 2'b11) || (awsize > 3'(LANE_SH)) ||
                      (awburst == 2'b10 && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

   assign err_slv_nxt = err_slv_q || id_bad || (wlast != (cnt_q == len_q));
   assign err_dec_nxt = err_dec_q || oob;

   always_comb begin
      bytes   = ADDR_WIDTH'(1) << size_q;
      aligned = addr_q & ~(bytes - 1'b1);
      inc     = aligned + bytes;
      wmask   = ((ADDR_WIDTH'(len_q) + 1'b1) << size_q) - 1'b1;
      case (burst_q)
         2'b01:   addr_nxt = inc;
         2'b10:   addr_nxt = (addr_q & ~wmask) | (inc & wmask);
         default: addr_nxt = addr_q;
      endcase
   end

   // state register; handshake outputs are registered copies of the next state
   always_ff @(posedge sig_clock or negedge sig_reset) begin
      if (!sig_reset) begin
         state   <= IDLE;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
      end else begin
         state   <= state_nxt;
         awready <= awready_nxt;
         wready  <= wready_nxt;
         bvalid  <= bvalid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (aw_hs) state_nxt = DATA;
         DATA:    if (beat_last) state_nxt = RESP;
         RESP:    if (bvalid && bready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      awready_nxt = state_nxt == IDLE;
      wready_nxt  = state_nxt == DATA;
      bvalid_nxt  = state_nxt == RESP;
   end

   always_ff @(posedge sig_clock or negedge sig_reset) begin
      if (!sig_reset) begin
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         bad_q     <= 1'b0;
         err_slv_q <= 1'b0;
         err_dec_q <= 1'b0;
         bid       <= '0;
         bresp     <= 2'b00;
      end else begin
         if (aw_hs) begin
            id_q      <= awid;
            addr_q    <= awaddr;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= awburst;
            cnt_q     <= '0;
            bad_q     <= illegal;
            err_slv_q <= illegal;
            err_dec_q <= 1'b0;
         end else if (w_hs) begin
            cnt_q     <= cnt_q + 8'd1;
            addr_q    <= addr_nxt;
            err_slv_q <= err_slv_nxt;
            err_dec_q <= err_dec_nxt;
         end
         if (beat_last) begin
            bid   <= id_q;
            bresp <= err_dec_nxt ? 2'b11 : (err_slv_nxt ? 2'b10 : 2'b00);
         end
      end
   end

   always_ff @(posedge sig_clock) begin
      if (we)
         for (int i = 0; i < STRB_WIDTH; i++)
            if (wstrb[i]) mem[addr_q[LANE_SH +: IDX_W]][8*i +: 8] <= wdata[8*i +: 8];
   end

   always_ff @(posedge sig_clock or negedge sig_reset) begin
      if (!sig_reset) mem_rdata <= '0;
      else            mem_rdata <= mem[mem_idx];
   end
endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Bench for axi_wr_slave_mem: directed and random bursts against a byte-level memory model
// that derives beat addresses and responses arithmetically.
module tb_axi_wr_slave_mem;
   localparam int MD = 256;

   logic        sig_clock = 1'b0, sig_reset = 1'b0;
   logic [7:0]  awid = '0, wid = '0, bid;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0, bresp;
   logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic [63:0] wdata = '0, mem_rdata;
   logic [7:0]  wstrb = '0, mem_idx = '0;
   logic        bvalid, bready = 1'b0;

   always #5 sig_clock = ~sig_clock;

   axi_wr_slave_mem dut (
      .sig_clock(sig_clock), .sig_reset(sig_reset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .mem_idx(mem_idx), .mem_rdata(mem_rdata)
   );

   logic [63:0] mm [MD];
   logic [63:0] bd [16];
   logic [7:0]  bs [16];
   logic [7:0]  bw [16];
   logic        bl [16];
   int          vec = 0, errs = 0;
   bit          col_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] st, input int n, input int sz,
                                             input int bt, input int ln);
      longint s, bytes, al, wb, base;
      s = longint'(st);
      bytes = longint'(1) << sz;
      al = s - (s % bytes);
      if (n == 0 || bt == 0 || bt == 3) return st;
      if (bt == 1) return 32'(al + n * bytes);
      wb = (ln + 1) * bytes;
      base = s - (s % wb);
      return 32'(base + ((al - base) + n * bytes) % wb);
   endfunction

   task automatic rdchk(input int idx, input logic [63:0] exp, input string nm);
      mem_idx = 8'(idx);
      @(negedge sig_clock);
      chk(nm, mem_rdata, exp);
   endtask

   task automatic scan();
      for (int i = 0; i < MD; i++) rdchk(i, mm[i], $sformatf("mem[%0d]", i));
   endtask

   task automatic idle_stray();
      wvalid = 1'b1; wid = awid; wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b1;
      @(negedge sig_clock);
      chk("wready_idle", wready, 1'b0);
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   // Model expectations for one burst using bd/bs/bw/bl, then drive it and check the DUT.
   task automatic burst(input logic [7:0] id, input logic [31:0] st, input int ln, input int sz,
                        input int bt, input int hold, output logic [1:0] rsp);
      bit illegal, slv, dec;
      int e, t, idx, widx;
      logic [31:0] a;
      logic [63:0] old;
      illegal = (bt == 3) || (sz > 3) || (bt == 2 && !(ln inside {1, 3, 7, 15}));
      slv = illegal; dec = 1'b0;
      e = ln;
      for (int n = 0; n <= ln; n++) if (bl[n]) begin e = n; break; end
      if (e < ln || !bl[e]) slv = 1'b1;
      for (int n = 0; n <= e; n++) begin
         if (bw[n] != id) slv = 1'b1;
         if (!illegal && beat_addr(st, n, sz, bt, ln) / 8 >= MD) dec = 1'b1;
      end
      rsp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);

      awid = id; awaddr = st; awlen = 8'(ln); awsize = 3'(sz); awburst = 2'(bt); awvalid = 1'b1;
      t = 0;
      while (!awready && t < 20) begin @(negedge sig_clock); t++; end
      if (!awready) begin
         chk("awready_timeout", 1'b0, 1'b1);
         awvalid = 1'b0;
         return;
      end
      @(negedge sig_clock);
      awvalid = 1'b0;
      chk("wready_after_aw", wready, 1'b1);
      chk("awready_busy", awready, 1'b0);
      for (int n = 0; n <= e; n++) begin
         wid = bw[n]; wdata = bd[n]; wstrb = bs[n]; wlast = bl[n]; wvalid = 1'b1;
         a = beat_addr(st, n, sz, bt, ln);
         idx = int'(a / 8);
         widx = idx % MD;
         old = mm[widx];
         if (n == 0) mem_idx = 8'(widx);
         @(negedge sig_clock);
         if (n == 0 && col_en) chk("rd_old_during_write", mem_rdata, old);
         if (!illegal && bw[n] == id && idx < MD)
            for (int i = 0; i < 8; i++) if (bs[n][i]) mm[widx][8*i +: 8] = bd[n][8*i +: 8];
         if (n < e) begin
            chk("wready_mid", wready, 1'b1);
            chk("bvalid_mid", bvalid, 1'b0);
         end
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("wready_drop", wready, 1'b0);
      chk("bvalid_rise", bvalid, 1'b1);
      chk("bid", bid, id);
      chk("bresp", bresp, rsp);
      for (int h = 0; h < hold; h++) begin
         wvalid = 1'b1; wid = id; wdata = {$urandom, $urandom}; wstrb = 8'hFF;
         @(negedge sig_clock);
         chk("bvalid_hold", bvalid, 1'b1);
         chk("bid_hold", bid, id);
         chk("bresp_hold", bresp, rsp);
         chk("awready_hold", awready, 1'b0);
         chk("wready_resp", wready, 1'b0);
      end
      wvalid = 1'b0;
      bready = 1'b1;
      @(negedge sig_clock);
      bready = 1'b0;
      chk("bvalid_drop", bvalid, 1'b0);
      chk("awready_back", awready, 1'b1);
   endtask

   task automatic set_beats(input int ln, input logic [7:0] id);
      for (int n = 0; n < 16; n++) begin
         bd[n] = {$urandom, $urandom}; bs[n] = 8'hFF; bw[n] = id; bl[n] = (n == ln);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  rsp;
      logic [7:0]  id;
      logic [31:0] st;
      logic [63:0] o8, o65, o98;
      int ln, sz, bt, k, m;

      repeat (3) @(negedge sig_clock);
      chk("rst_awready", awready, 1'b0);
      chk("rst_wready", wready, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_bid", bid, 8'h00);
      chk("rst_bresp", bresp, 2'b00);
      chk("rst_mem_rdata", mem_rdata, 64'h0);
      sig_reset = 1'b1;
      @(negedge sig_clock);
      chk("awready_after_release", awready, 1'b1);

      // fill the whole memory so every later readback has a known value
      for (int b = 0; b < MD / 16; b++) begin
         set_beats(15, 8'h00);
         burst(8'h00, 32'(b * 128), 15, 3, 1, 0, rsp);
      end
      col_en = 1'b1;
      scan();

      // INCR id=5 addr 0x10 with bready held low for 5 cycles
      set_beats(3, 8'd5);
      for (int n = 0; n < 4; n++) bd[n] = 64'hC0DE_0000_0000_0000 | 64'(n);
      burst(8'd5, 32'h10, 3, 3, 1, 5, rsp);
      chk("t1_model_bresp", rsp, 2'b00);
      rdchk(2, 64'hC0DE_0000_0000_0000, "t1_word2");
      rdchk(5, 64'hC0DE_0000_0000_0003, "t1_word5");
      idle_stray();

      // FIXED with complementary strobes
      set_beats(1, 8'd7);
      bd[0] = 64'h0123_4567_89AB_CDEF; bs[0] = 8'h0F;
      bd[1] = 64'hFEDC_BA98_7654_3210; bs[1] = 8'hF0;
      burst(8'd7, 32'h08, 1, 3, 0, 0, rsp);
      chk("t2_model_bresp", rsp, 2'b00);
      rdchk(1, 64'hFEDC_BA98_89AB_CDEF, "t2_word1");

      // WRAP from 0x18 lands on words 3,0,1,2
      set_beats(3, 8'd3);
      for (int n = 0; n < 4; n++) bd[n] = 64'hAAAA_0000_0000_0000 | 64'(n);
      burst(8'd3, 32'h18, 3, 3, 2, 1, rsp);
      rdchk(3, 64'hAAAA_0000_0000_0000, "t3_word3");
      rdchk(0, 64'hAAAA_0000_0000_0001, "t3_word0");
      rdchk(1, 64'hAAAA_0000_0000_0002, "t3_word1");
      rdchk(2, 64'hAAAA_0000_0000_0003, "t3_word2");

      // WRAP with len=2 is illegal: SLVERR, no writes
      o8 = mm[8];
      set_beats(2, 8'd4);
      burst(8'd4, 32'h40, 2, 3, 2, 0, rsp);
      chk("t4_model_bresp", rsp, 2'b10);
      rdchk(8, o8, "t4_word8_unchanged");

      // early wlast on beat 1 of a len=3 burst
      set_beats(3, 8'd6);
      bl[3] = 1'b0; bl[1] = 1'b1;
      burst(8'd6, 32'h100, 3, 3, 1, 0, rsp);
      chk("t5_model_bresp", rsp, 2'b10);

      // wid mismatch on beat 1
      o65 = mm[65];
      set_beats(1, 8'd9);
      bw[1] = 8'd8;
      burst(8'd9, 32'h200, 1, 3, 1, 0, rsp);
      chk("t6_model_bresp", rsp, 2'b10);
      rdchk(65, o65, "t6_word65_unchanged");

      // one past the end of memory decodes to DECERR
      set_beats(0, 8'd2);
      burst(8'd2, 32'(MD * 8), 0, 3, 1, 0, rsp);
      chk("t7_model_bresp", rsp, 2'b11);

      // reset in the middle of a burst after two beats
      set_beats(7, 8'd1);
      o98 = mm[98];
      awid = 8'd1; awaddr = 32'h300; awlen = 8'd7; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
      @(negedge sig_clock);
      awvalid = 1'b0;
      for (int n = 0; n < 2; n++) begin
         wid = 8'd1; wdata = bd[n]; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
         @(negedge sig_clock);
         mm[96 + n] = bd[n];
      end
      wdata = bd[2];
      sig_reset = 1'b0;
      #1;
      chk("mid_rst_awready", awready, 1'b0);
      chk("mid_rst_wready", wready, 1'b0);
      chk("mid_rst_bvalid", bvalid, 1'b0);
      chk("mid_rst_bid", bid, 8'h00);
      chk("mid_rst_bresp", bresp, 2'b00);
      chk("mid_rst_mem_rdata", mem_rdata, 64'h0);
      wvalid = 1'b0;
      @(negedge sig_clock);
      sig_reset = 1'b1;
      @(negedge sig_clock);
      chk("mid_rst_awready_back", awready, 1'b1);
      chk("mid_rst_no_bvalid", bvalid, 1'b0);
      rdchk(96, mm[96], "mid_rst_word96");
      rdchk(97, mm[97], "mid_rst_word97");
      rdchk(98, o98, "mid_rst_word98");

      // random bursts; illegal ones stay low and short so they never decode out of range
      for (int r = 0; r < 60; r++) begin
         id = 8'($urandom);
         k = $urandom_range(0, 9);
         if (k == 0) begin
            ln = $urandom_range(0, 3); st = 32'($urandom_range(0, 255)); sz = 3; bt = 1;
            case ($urandom_range(0, 2))
               0: bt = 3;
               1: sz = $urandom_range(4, 7);
               default: begin bt = 2; ln = 2; end
            endcase
         end else begin
            bt = $urandom_range(0, 2);
            sz = $urandom_range(0, 3);
            ln = (bt == 2) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
            st = (k == 1) ? 32'(MD * 8 - 32 + $urandom_range(0, 31)) : 32'($urandom_range(0, MD * 8 - 1));
         end
         set_beats(ln, id);
         for (int n = 0; n < 16; n++) begin
            bs[n] = 8'($urandom);
            if ($urandom_range(0, 9) == 0) bw[n] = id ^ 8'h01;
         end
         m = $urandom_range(0, 7);
         if (m == 0 && ln > 0) begin bl[ln] = 1'b0; bl[$urandom_range(0, ln - 1)] = 1'b1; end
         else if (m == 1) bl[ln] = 1'b0;
         burst(id, st, ln, sz, bt, $urandom_range(0, 3), rsp);
         if (r % 8 == 0) idle_stray();
      end
      scan();

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
